// File: rtl/sprite_engine.sv
// Scaled ROM sprite renderer with per-frame position latch, colour-key transparency
// and a hit-point state machine (flash, dying, dead). Outputs trail the pixel inputs by ROM_LATENCY+1.
module sprite_engine #(
  parameter int          COL_W        = 12,
  parameter int          ROW_W        = 11,
  parameter int          IMG_W_LOG2   = 6,
  parameter int          IMG_H_LOG2   = 6,
  parameter int          SCALE_SHIFT  = 2,
  parameter logic [11:0] KEY_COLOR    = 12'hC0F,
  parameter int          ROM_LATENCY  = 1,
  parameter int          HP_INIT      = 3,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             visible,
  input  logic                             frame_start,
  input  logic [COL_W-1:0]                 display_col,
  input  logic [ROW_W-1:0]                 display_row,
  input  logic [COL_W-1:0]                 base_x,
  input  logic [ROW_W-1:0]                 base_y,
  input  logic                             hit,
  output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] rom_addr,
  input  logic [11:0]                      rom_data,
  output logic [3:0]                       sprite_red,
  output logic [3:0]                       sprite_green,
  output logic [3:0]                       sprite_blue,
  output logic                             sprite_visible,
  output logic [3:0]                       hp,
  output logic                             defeated
);
  localparam logic [COL_W:0] SPAN_X  = (COL_W+1)'(1) << (IMG_W_LOG2 + SCALE_SHIFT);
  localparam logic [ROW_W:0] SPAN_Y  = (ROW_W+1)'(1) << (IMG_H_LOG2 + SCALE_SHIFT);
  localparam logic [7:0]     FC_LAST = 8'(FLASH_FRAMES - 1);

  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_FLASH = 2'd1;
  localparam logic [1:0] ST_DYING = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  logic [COL_W-1:0]      bx;
  logic [ROW_W-1:0]      by;
  logic [1:0]            state;
  logic [7:0]            fc;
  logic [ROM_LATENCY:1]  vld_pipe;
  logic                  in_win, blink_on, drawn;
  logic [COL_W:0]        col_x, bx_x;
  logic [ROW_W:0]        row_x, by_x;
  logic [IMG_W_LOG2-1:0] tx;
  logic [IMG_H_LOG2-1:0] ty;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bx <= '0;
      by <= '0;
    end else if (frame_start) begin
      bx <= base_x;
      by <= base_y;
    end

  // One extra bit so the window end never wraps around the coordinate range.
  assign col_x  = {1'b0, display_col};
  assign row_x  = {1'b0, display_row};
  assign bx_x   = {1'b0, bx};
  assign by_x   = {1'b0, by};
  assign in_win = visible && (col_x >= bx_x) && (col_x < bx_x + SPAN_X)
                          && (row_x >= by_x) && (row_x < by_x + SPAN_Y);
  assign tx     = IMG_W_LOG2'((display_col - bx) >> SCALE_SHIFT);
  assign ty     = IMG_H_LOG2'((display_row - by) >> SCALE_SHIFT);

  always_ff @(posedge clock or posedge reset)
    if (reset)       rom_addr <= '0;
    else if (in_win) rom_addr <= {ty, tx};

  always_ff @(posedge clock or posedge reset)
    if (reset) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= in_win;
      for (int i = 2; i <= ROM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end

  assign blink_on = (state == ST_FLASH) ? ~fc[0] : 1'b1;
  assign drawn    = vld_pipe[ROM_LATENCY] && (rom_data != KEY_COLOR) && blink_on
                    && (state != ST_DEAD);

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {sprite_blue, sprite_green, sprite_red} <= 12'hFFF;
      sprite_visible <= 1'b0;
    end else if (drawn) begin
      {sprite_blue, sprite_green, sprite_red} <= (state == ST_DYING) ? ~rom_data : rom_data;
      sprite_visible <= 1'b1;
    end else begin
      {sprite_blue, sprite_green, sprite_red} <= 12'hFFF;
      sprite_visible <= 1'b0;
    end

  // A hit in ALIVE wins over a coincident frame_start, which is then not counted.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_ALIVE;
      hp    <= 4'(HP_INIT);
      fc    <= '0;
    end else begin
      case (state)
        ST_ALIVE:
          if (hit) begin
            fc <= '0;
            if (hp > 4'd1) begin
              hp    <= hp - 4'd1;
              state <= ST_FLASH;
            end else begin
              hp    <= '0;
              state <= ST_DYING;
            end
          end
        ST_FLASH, ST_DYING:
          if (frame_start) begin
            if (fc == FC_LAST) begin
              fc    <= '0;
              state <= (state == ST_FLASH) ? ST_ALIVE : ST_DEAD;
            end else begin
              fc <= fc + 8'd1;
            end
          end
        default: ;
      endcase
    end

  assign defeated = (state == ST_DEAD);
endmodule

// File: tb/tb_sprite_engine.sv
// Randomized bench for sprite_engine against a frame/hit-level reference model and a modelled ROM.
module tb_sprite_engine;
  localparam int          SPAN = 256;
  localparam int          SC   = 2;
  localparam int          IMGW = 64;
  localparam int          HPI  = 3;
  localparam int          FF   = 4;
  localparam logic [11:0] KEY  = 12'hC0F;
  localparam int M_ALIVE = 0, M_FLASH = 1, M_DYING = 2, M_DEAD = 3;

  logic        clock = 1'b0, reset = 1'b1;
  logic        visible = 1'b0, frame_start = 1'b0, hit = 1'b0;
  logic [11:0] display_col = '0, base_x = '0;
  logic [10:0] display_row = '0, base_y = '0;
  logic [11:0] rom_addr, rom_data;
  logic [3:0]  sprite_red, sprite_green, sprite_blue, hp;
  logic        sprite_visible, defeated;

  logic [11:0] rom_mem [0:4095];
  assign rom_data = rom_mem[rom_addr];

  sprite_engine #(.HP_INIT(HPI), .FLASH_FRAMES(FF)) dut (
    .clock(clock), .reset(reset), .visible(visible), .frame_start(frame_start),
    .display_col(display_col), .display_row(display_row), .base_x(base_x), .base_y(base_y),
    .hit(hit), .rom_addr(rom_addr), .rom_data(rom_data),
    .sprite_red(sprite_red), .sprite_green(sprite_green), .sprite_blue(sprite_blue),
    .sprite_visible(sprite_visible), .hp(hp), .defeated(defeated));

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int m_bx, m_by, m_hp, m_mode, m_frames, m_addr;
  logic [12:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Called one step after a rising edge; applies one pixel and advances one clock.
  task automatic cycle(input logic v, input int col, input int row, input logic fs,
                       input logic h, input int bxi, input int byi);
    logic [11:0] tex;
    bit inw, drawn;
    check("pixel", {sprite_visible, sprite_blue, sprite_green, sprite_red}, exp_q.pop_front());
    check("rom_addr", rom_addr, m_addr);
    check("hp", hp, m_hp);
    check("defeated", defeated, m_mode == M_DEAD);
    inw = v && col >= m_bx && col < m_bx + SPAN && row >= m_by && row < m_by + SPAN;
    if (inw) m_addr = ((row - m_by) >> SC) * IMGW + ((col - m_bx) >> SC);
    tex = rom_mem[m_addr];
    if (fs) begin m_bx = bxi; m_by = byi; end
    if (m_mode == M_ALIVE) begin
      if (h) begin
        m_frames = 0;
        if (m_hp > 1) begin m_hp--; m_mode = M_FLASH; end
        else begin m_hp = 0; m_mode = M_DYING; end
      end
    end else if (m_mode != M_DEAD && fs) begin
      m_frames++;
      if (m_frames == FF) m_mode = (m_mode == M_FLASH) ? M_ALIVE : M_DEAD;
    end
    drawn = inw && tex != KEY && m_mode != M_DEAD && !(m_mode == M_FLASH && m_frames % 2 == 1);
    exp_q.push_back(drawn ? {1'b1, (m_mode == M_DYING) ? ~tex : tex} : 13'h0FFF);
    visible = v; display_col = 12'(col); display_row = 11'(row);
    frame_start = fs; hit = h; base_x = 12'(bxi); base_y = 11'(byi);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_pixel", {sprite_visible, sprite_blue, sprite_green, sprite_red}, 13'h0FFF);
    check("rst_addr", rom_addr, 0);
    check("rst_hp", hp, HPI);
    check("rst_defeated", defeated, 0);
    m_bx = 0; m_by = 0; m_hp = HPI; m_mode = M_ALIVE; m_frames = 0; m_addr = 0;
    exp_q = {13'h0FFF, 13'h0FFF};
    visible = 0; frame_start = 0; hit = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic frame();
    repeat (6) cycle(1, m_bx, m_by, 0, 0, m_bx, m_by);
    cycle(1, m_bx, m_by, 1, 0, m_bx, m_by);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int col, row, bxi, byi;
    logic v, fs, h;
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    rom_mem[0] = 12'h3A5;
    rom_mem[1] = KEY;
    @(posedge clock); #1;
    do_reset();

    // window edges and latency
    cycle(0, 0, 0, 1, 0, 0, 565);
    cycle(1, 0, 565, 0, 0, 0, 565);
    cycle(1, 4, 565, 0, 0, 0, 565);
    cycle(1, 255, 820, 0, 0, 0, 565);
    cycle(1, 256, 565, 0, 0, 0, 565);
    cycle(1, 0, 564, 0, 0, 0, 565);
    cycle(1, 255, 821, 0, 0, 0, 565);
    cycle(0, 0, 565, 0, 0, 0, 565);
    // mid-frame base change takes effect only at frame_start
    cycle(1, 100, 565, 0, 0, 100, 565);
    cycle(1, 0, 0, 1, 0, 100, 565);
    cycle(1, 100, 565, 0, 0, 100, 565);
    cycle(1, 99, 565, 0, 0, 100, 565);
    // flash with an ignored hit
    cycle(1, m_bx, m_by, 0, 1, m_bx, m_by);
    frame(); frame();
    cycle(1, m_bx, m_by, 0, 1, m_bx, m_by);
    repeat (3) frame();
    // death, inverted colours, then reset during DYING
    cycle(1, m_bx, m_by, 0, 1, m_bx, m_by);
    repeat (5) frame();
    cycle(1, m_bx, m_by, 0, 1, m_bx, m_by);
    frame(); frame();
    do_reset();
    // full death to DEAD
    repeat (3) begin
      cycle(1, m_bx, m_by, 0, 1, m_bx, m_by);
      repeat (5) frame();
    end
    repeat (2) frame();
    do_reset();
    // hit coincident with frame_start
    cycle(1, m_bx, m_by, 1, 1, m_bx, m_by);
    repeat (5) frame();

    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      v   = $urandom_range(0, 9) != 0;
      fs  = $urandom_range(0, 29) == 0;
      h   = $urandom_range(0, 49) == 0;
      col = (m_bx + int'($urandom_range(0, 300)) - 20) & 4095;
      row = (m_by + int'($urandom_range(0, 300)) - 20) & 2047;
      bxi = ($urandom_range(0, 3) == 0) ? 4095 - int'($urandom_range(0, 200)) : int'($urandom_range(0, 4095));
      byi = ($urandom_range(0, 3) == 0) ? 2047 - int'($urandom_range(0, 200)) : int'($urandom_range(0, 2047));
      cycle(v, col, row, fs, h, bxi, byi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
Parametrised successor to the fixed-position boss renderer. Draws one scaled ROM sprite at a per-frame position, with colour-key transparency and a hit-point state machine (hit flash, death animation, defeated). It sits between the VGA timing generator and the pixel mixer, and drives an external synchronous sprite ROM. Outputs are pipeline-aligned to the ROM read latency.

Parameters:
COL_W, 12, width of display_col / base_x
ROW_W, 11, width of display_row / base_y
IMG_W_LOG2, 6, log2 of sprite width in texels (64)
IMG_H_LOG2, 6, log2 of sprite height in texels (64)
SCALE_SHIFT, 2, each texel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT pixels
KEY_COLOR, 12'hC0F, transparent ROM value
ROM_LATENCY, 1, ROM read latency in cycles (1..3)
HP_INIT, 3, hit points after reset (1..15)
FLASH_FRAMES, 8, frames spent in FLASH and in DYING (1..255)

Ports:
clock  in  1  pixel clock
reset  in  1  async, active-high
visible  in  1  display active area
frame_start  in  1  one-cycle pulse at the start of each frame
display_col  in  COL_W  current pixel column
display_row  in  ROW_W  current pixel row
base_x  in  COL_W  sprite left edge, sampled on frame_start
base_y  in  ROW_W  sprite top edge, sampled on frame_start
hit  in  1  one-cycle hit pulse
rom_addr  out  IMG_W_LOG2+IMG_H_LOG2  texel address
rom_data  in  12  texel, {blue[11:8], green[7:4], red[3:0]}
sprite_red, sprite_green, sprite_blue  out  4 each  pixel colour
sprite_visible  out  1  sprite pixel is opaque and drawn
hp  out  4  remaining hit points
defeated  out  1  high in DEAD

Behaviour:
- Interface: reset is asynchronous and active-high; all state is clocked on clock.
- Reset values:
  - colours 4'hF, sprite_visible 0, rom_addr 0
  - hp = HP_INIT, defeated 0, state ALIVE
  - frame counter 0, latched base_x/base_y 0
- Position latch:
  - base_x/base_y are registered on frame_start only.
  - Changes mid-frame take effect from the next frame, so the sprite never tears.
- Stage 0 (cycle 0):
  - SPAN_X = 2^(IMG_W_LOG2+SCALE_SHIFT); SPAN_Y is defined the same way.
  - in_win = visible && col in [bx, bx+SPAN_X) && row in [by, by+SPAN_Y). The window is half-open.
  - The comparison uses COL_W+1 / ROW_W+1 bit arithmetic so bx+SPAN_X never wraps.
  - rom_addr <= {(row-by)>>SCALE_SHIFT, (col-bx)>>SCALE_SHIFT}, each field truncated to IMG_H_LOG2 / IMG_W_LOG2. The address is row-major.
  - Outside the window, rom_addr holds its previous value.
- Delay line: in_win is delayed ROM_LATENCY cycles to match rom_data.
- Output stage:
  - Registered; total latency from display_col/row to the outputs is ROM_LATENCY+1 cycles.
  - Opaque pixel: drawn = delayed in_win && rom_data != KEY_COLOR && blink_on && state != DEAD.
  - When drawn: colours come from rom_data and sprite_visible = 1. In DYING, each channel is inverted (4'hF - c).
  - When not drawn: colours 4'hF and sprite_visible 0.
- State machine (frame counter fc is 8 bits):
  - ALIVE: blink_on = 1.
    - On hit with hp > 1: hp--, fc <= 0, go to FLASH.
    - On hit with hp == 1: hp <= 0, fc <= 0, go to DYING.
  - FLASH: blink_on = ~fc[0] (sprite shown on even frames).
    - fc increments on each frame_start.
    - When fc == FLASH_FRAMES-1 and frame_start arrives: go to ALIVE.
    - hit is ignored (invulnerable).
  - DYING: blink_on = 1, colours inverted.
    - fc increments on each frame_start.
    - Exits to DEAD under the same condition as FLASH.
    - hit is ignored.
  - DEAD: sprite_visible 0, defeated 1. hit is ignored. Only reset leaves DEAD.
- Simultaneous hit and frame_start in ALIVE: the hit is taken and fc = 0. That frame_start is not counted.
- State changes apply at the next cycle's output stage. The pixel pipeline is not flushed.
- Reset mid-frame or mid-animation returns to the full reset values immediately, because reset is asynchronous.

Test Plan:
1. Window and latency: base 0/565, SCALE_SHIFT=2, ROM_LATENCY=1; col=0,row=565 -> rom_addr=0 after 1 cycle, outputs after 2 cycles. col=256 -> sprite_visible 0 (half-open edge). col=255,row=820 -> rom_addr=12'hFFF.
2. Transparency: ROM returns 12'hC0F at one texel and 12'h3A5 at its neighbour -> first gives sprite_visible 0 with colours F/F/F; second gives red=5, green=A, blue=3, sprite_visible 1.
3. Position latch: change base_x from 0 to 100 mid-frame -> rendering is unchanged until the next frame_start, then col=100 maps to rom_addr=0.
4. Flash: HP_INIT=3, FLASH_FRAMES=4, hit -> hp=2. Sprite hidden on frames 1 and 3 after the hit. A hit during FLASH leaves hp=2. After 4 frame_starts, state is ALIVE.
5. Death: three spaced hits -> hp=0 and DYING. Texel 12'h3A5 outputs red=A, green=5, blue=C. After 4 frame_starts, defeated=1 and sprite_visible stays 0.
6. Reset: assert reset during DYING with no clock edge -> hp=3, defeated 0, colours F, sprite_visible 0. Hit together with frame_start in ALIVE -> FLASH with fc=0.
